// File: rtl/vector_lane_sequencer_pkg.sv
// Shared definitions for the vector lane sequencer: FSM state encoding,
// element-width codes and the ALU opcodes forwarded to the lanes.
package vector_lane_sequencer_pkg;

   // Sequencer FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_EXEC = 3'd2,
      ST_WB   = 3'd3,
      ST_DONE = 3'd4
   } seq_state_e;

   // Element width codes (vsew field), forwarded unchanged to the lanes.
   localparam logic [2:0] VSEW_8  = 3'b000;
   localparam logic [2:0] VSEW_16 = 3'b001;
   localparam logic [2:0] VSEW_32 = 3'b010;
   localparam logic [2:0] VSEW_64 = 3'b011;

   // ALU opcodes (funct6-style encodings).
   localparam logic [5:0] VECTOR_ADD  = 6'b000000;
   localparam logic [5:0] VECTOR_SUB  = 6'b000010;
   localparam logic [5:0] VECTOR_ADC  = 6'b010000;
   localparam logic [5:0] VECTOR_MADC = 6'b010001;
   localparam logic [5:0] VECTOR_SBC  = 6'b010010;
   localparam logic [5:0] VECTOR_MSBC = 6'b010011;

endpackage

// File: rtl/vector_lane_sequencer_enable_gen.sv
// Per-lane write-enable generation for one element group. An element is
// written only when it lies in the body (index < vl) and is either active
// in the mask or the mask is not acting as a predicate (unmasked op, or the
// mask is a carry/borrow operand). Shared with the load/store unit.
module vector_lane_enable_gen #(
   parameter int LANE_NUM         = 2,
   parameter int ENTRY_INDEX_SIZE = 3
) (
   input  logic [ENTRY_INDEX_SIZE:0] base,
   input  logic [ENTRY_INDEX_SIZE:0] vl,
   input  logic                      vm,
   input  logic                      mask_as_operand,
   input  logic [LANE_NUM-1:0]       lane_mask,
   output logic [LANE_NUM-1:0]       lane_en
);

   // One extra bit so base+lane never wraps before the compare against vl.
   localparam int EW = ENTRY_INDEX_SIZE + 2;

   for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
      logic [EW-1:0] elem;
      logic          in_body;
      logic          active;

      assign elem       = {1'b0, base} + EW'(l);
      assign in_body    = elem < {1'b0, vl};
      assign active     = vm || mask_as_operand || lane_mask[l];
      assign lane_en[l] = in_body && active;
   end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Vector lane sequencer: accepts one vector arithmetic instruction, then
// walks its elements in groups of LANE_NUM through READ -> EXEC -> WB,
// reading vs1/vs2/v0, loading the lane operand registers and writing the
// lane results back to vd with per-lane enables.
module vector_lane_sequencer
   import vector_lane_sequencer_pkg::*;
#(
   parameter int LANE_NUM         = 2,
   parameter int LANE_INDEX_SIZE  = 1,
   parameter int VECTOR_SIZE      = 8,
   parameter int ENTRY_INDEX_SIZE = 3,
   parameter int LONGEST_LEN      = 64
) (
   input  logic                            clk,
   input  logic                            rst,

   input  logic                            start_valid,
   output logic                            start_ready,
   input  logic [ENTRY_INDEX_SIZE:0]       vl,
   input  logic [2:0]                      vsew,
   input  logic                            vm,
   input  logic                            mask_as_operand,
   input  logic [5:0]                      opcode,
   input  logic [4:0]                      vs1_idx,
   input  logic [4:0]                      vs2_idx,
   input  logic [4:0]                      vd_idx,

   output logic                            rf_rd_en,
   output logic [4:0]                      rf_rd_vs1,
   output logic [4:0]                      rf_rd_vs2,
   output logic [ENTRY_INDEX_SIZE-1:0]     rf_rd_base,
   input  logic [LANE_NUM*LONGEST_LEN-1:0] rf_vs1_data,
   input  logic [LANE_NUM*LONGEST_LEN-1:0] rf_vs2_data,
   input  logic [LANE_NUM-1:0]             rf_mask,

   output logic [LANE_NUM*LONGEST_LEN-1:0] lane_vs1,
   output logic [LANE_NUM*LONGEST_LEN-1:0] lane_vs2,
   output logic [LANE_NUM-1:0]             lane_mask,
   output logic [2:0]                      lane_vsew,
   output logic [5:0]                      lane_opcode,
   output logic                            lane_vm,
   input  logic [LANE_NUM*LONGEST_LEN-1:0] lane_result,

   output logic                            wb_en,
   output logic [4:0]                      wb_vd,
   output logic [ENTRY_INDEX_SIZE-1:0]     wb_base,
   output logic [LANE_NUM-1:0]             wb_lane_en,
   output logic [LANE_NUM*LONGEST_LEN-1:0] wb_data,

   output logic                            busy,
   output logic                            done
);

   // Base counter is one bit wider than an element index so that a full
   // vector (vl == VECTOR_SIZE) ends with base == VECTOR_SIZE, not 0.
   localparam int               CW        = ENTRY_INDEX_SIZE + 1;
   localparam logic [CW-1:0]    BASE_STEP = CW'(1 << LANE_INDEX_SIZE);
   localparam logic [CW-1:0]    VL_MAX    = CW'(VECTOR_SIZE);

   seq_state_e     state;
   seq_state_e     state_next;

   // Instruction configuration, held constant for the whole instruction.
   logic [CW-1:0]  vl_q;
   logic [2:0]     vsew_q;
   logic           vm_q;
   logic           mask_as_operand_q;
   logic [5:0]     opcode_q;
   logic [4:0]     vs1_q;
   logic [4:0]     vs2_q;
   logic [4:0]     vd_q;

   logic [CW-1:0]  base;
   logic [CW-1:0]  base_next;
   logic [CW-1:0]  vl_clamped;
   logic           accept;
   logic           last_group;
   logic [LANE_NUM-1:0] lane_en;

   assign accept     = start_valid && start_ready;
   assign vl_clamped = (vl > VL_MAX) ? VL_MAX : vl;
   assign base_next  = base + BASE_STEP;
   assign last_group = base_next >= vl_q;

   assign rf_rd_vs1  = vs1_q;
   assign rf_rd_vs2  = vs2_q;
   assign rf_rd_base = base[ENTRY_INDEX_SIZE-1:0];

   vector_lane_enable_gen #(
      .LANE_NUM         (LANE_NUM),
      .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE)
   ) u_enable_gen (
      .base            (base),
      .vl              (vl_q),
      .vm              (vm_q),
      .mask_as_operand (mask_as_operand_q),
      .lane_mask       (lane_mask),
      .lane_en         (lane_en)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment so every
         // flop samples pre-edge values regardless of block ordering.
         state <= state_next;
      end
   end

   // Next-state decode and the state-derived handshake/strobe outputs.
   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path can
      // leave one unassigned and infer a latch.
      state_next  = state;
      start_ready = 1'b0;
      busy        = 1'b1;
      rf_rd_en    = 1'b0;
      done        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               state_next = (vl_clamped == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            rf_rd_en   = 1'b1;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            state_next = ST_WB;
         end
         ST_WB: begin
            state_next = last_group ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Latch the instruction on accept; ignored while busy since ready is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vl_q              <= '0;
         vsew_q            <= '0;
         vm_q              <= 1'b0;
         mask_as_operand_q <= 1'b0;
         opcode_q          <= '0;
         vs1_q             <= '0;
         vs2_q             <= '0;
         vd_q              <= '0;
      end else if (accept) begin
         vl_q              <= vl_clamped;
         vsew_q            <= vsew;
         vm_q              <= vm;
         mask_as_operand_q <= mask_as_operand;
         opcode_q          <= opcode;
         vs1_q             <= vs1_idx;
         vs2_q             <= vs2_idx;
         vd_q              <= vd_idx;
      end
   end

   // Group base: cleared on accept, advanced by one group after each WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base <= '0;
      end else if (accept) begin
         base <= '0;
      end else if (state == ST_WB) begin
         base <= base_next;
      end
   end

   // Lane operand registers, loaded from the register file read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_vs1    <= '0;
         lane_vs2    <= '0;
         lane_mask   <= '0;
         lane_vsew   <= '0;
         lane_opcode <= '0;
         lane_vm     <= 1'b0;
      end else if (state == ST_EXEC) begin
         lane_vs1    <= rf_vs1_data;
         lane_vs2    <= rf_vs2_data;
         lane_mask   <= rf_mask;
         lane_vsew   <= vsew_q;
         lane_opcode <= opcode_q;
         lane_vm     <= vm_q;
      end
   end

   // Writeback register: captures lane results and enables at the end of WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en      <= 1'b0;
         wb_vd      <= '0;
         wb_base    <= '0;
         wb_lane_en <= '0;
         wb_data    <= '0;
      end else begin
         wb_en <= 1'b0;
         if (state == ST_WB) begin
            wb_en      <= 1'b1;
            wb_vd      <= vd_q;
            wb_base    <= base[ENTRY_INDEX_SIZE-1:0];
            wb_lane_en <= lane_en;
            wb_data    <= lane_result;
         end
      end
   end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer: behavioural register file and
// lane adder around the DUT, checks via immediate assertions.
module tb_vector_lane_sequencer;
   import vector_lane_sequencer_pkg::*;

   localparam int LN  = 2;
   localparam int EIS = 3;
   localparam int LL  = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_valid;
   logic              start_ready;
   logic [EIS:0]      vl;
   logic [2:0]        vsew;
   logic              vm;
   logic              mask_as_operand;
   logic [5:0]        opcode;
   logic [4:0]        vs1_idx, vs2_idx, vd_idx;
   logic              rf_rd_en;
   logic [4:0]        rf_rd_vs1, rf_rd_vs2;
   logic [EIS-1:0]    rf_rd_base;
   logic [LN*LL-1:0]  rf_vs1_data = '0;
   logic [LN*LL-1:0]  rf_vs2_data = '0;
   logic [LN-1:0]     rf_mask = '0;
   logic [LN*LL-1:0]  lane_vs1, lane_vs2;
   logic [LN-1:0]     lane_mask;
   logic [2:0]        lane_vsew;
   logic [5:0]        lane_opcode;
   logic              lane_vm;
   logic [LN*LL-1:0]  lane_result;
   logic              wb_en;
   logic [4:0]        wb_vd;
   logic [EIS-1:0]    wb_base;
   logic [LN-1:0]     wb_lane_en;
   logic [LN*LL-1:0]  wb_data;
   logic              busy;
   logic              done;

   logic [7:0]        v0 = 8'h00;

   int passed = 0;
   int total  = 0;

   // Results of the most recent instruction run.
   int               n_wb, done_cyc, rd_cnt, waits;
   logic             poke_ready;
   logic [4:0]       rd_vs1_last;
   logic [EIS-1:0]   wb_base_a [0:7];
   logic [LN-1:0]    wb_len_a  [0:7];
   logic [LN-1:0]    wb_mask_a [0:7];
   logic [4:0]       wb_vd_a   [0:7];
   logic [LN*LL-1:0] wb_data_a [0:7];

   vector_lane_sequencer #(
      .LANE_NUM         (LN),
      .LANE_INDEX_SIZE  (1),
      .VECTOR_SIZE      (8),
      .ENTRY_INDEX_SIZE (EIS),
      .LONGEST_LEN      (LL)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start_valid     (start_valid),
      .start_ready     (start_ready),
      .vl              (vl),
      .vsew            (vsew),
      .vm              (vm),
      .mask_as_operand (mask_as_operand),
      .opcode          (opcode),
      .vs1_idx         (vs1_idx),
      .vs2_idx         (vs2_idx),
      .vd_idx          (vd_idx),
      .rf_rd_en        (rf_rd_en),
      .rf_rd_vs1       (rf_rd_vs1),
      .rf_rd_vs2       (rf_rd_vs2),
      .rf_rd_base      (rf_rd_base),
      .rf_vs1_data     (rf_vs1_data),
      .rf_vs2_data     (rf_vs2_data),
      .rf_mask         (rf_mask),
      .lane_vs1        (lane_vs1),
      .lane_vs2        (lane_vs2),
      .lane_mask       (lane_mask),
      .lane_vsew       (lane_vsew),
      .lane_opcode     (lane_opcode),
      .lane_vm         (lane_vm),
      .lane_result     (lane_result),
      .wb_en           (wb_en),
      .wb_vd           (wb_vd),
      .wb_base         (wb_base),
      .wb_lane_en      (wb_lane_en),
      .wb_data         (wb_data),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [LL-1:0] elem_a(input int e);
      return 64'h0000_0100_0000_0000 + 64'(e);
   endfunction

   function automatic logic [LL-1:0] elem_b(input int e);
      return 64'h11 * 64'(e + 1);
   endfunction

   // Register file model: data and v0 bits one cycle after the read strobe.
   always @(posedge clk) begin
      if (rf_rd_en) begin
         for (int l = 0; l < LN; l++) begin
            rf_vs1_data[l*LL +: LL] <= elem_a(int'(rf_rd_base) + l);
            rf_vs2_data[l*LL +: LL] <= elem_b(int'(rf_rd_base) + l);
            rf_mask[l]              <= v0[int'(rf_rd_base) + l];
         end
      end
   end

   // Lane array model: every lane adds its two operands.
   for (genvar l = 0; l < LN; l++) begin : g_lane
      assign lane_result[l*LL +: LL] = lane_vs1[l*LL +: LL] + lane_vs2[l*LL +: LL];
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Offer an instruction and hold it until accepted (bounded).
   task automatic issue(input logic [3:0] v_l, input logic v_m, input logic mao,
                        input logic [5:0] op, input logic [4:0] d);
      start_valid     = 1'b1;
      vl              = v_l;
      vsew            = VSEW_64;
      vm              = v_m;
      mask_as_operand = mao;
      opcode          = op;
      vd_idx          = d;
      vs1_idx         = d + 5'd8;
      vs2_idx         = d + 5'd16;
      waits           = 0;
      while (!start_ready && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   // Watch one instruction until done (bounded); optionally poke start_valid.
   task automatic run_instr(input int poke_at);
      n_wb       = 0;
      rd_cnt     = 0;
      done_cyc   = -1;
      poke_ready = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == poke_at + 1) start_valid = 1'b0;
         if (c == poke_at) begin
            poke_ready  = start_ready;
            start_valid = 1'b1;
            vl          = 4'd3;
            vd_idx      = 5'd9;
            vs1_idx     = 5'd1;
            opcode      = VECTOR_SUB;
         end
         if (rf_rd_en) begin
            rd_cnt++;
            rd_vs1_last = rf_rd_vs1;
         end
         if (wb_en) begin
            if (n_wb < 8) begin
               wb_base_a[n_wb] = wb_base;
               wb_len_a[n_wb]  = wb_lane_en;
               wb_mask_a[n_wb] = lane_mask;
               wb_vd_a[n_wb]   = wb_vd;
               wb_data_a[n_wb] = wb_data;
            end
            n_wb++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      start_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start_valid = 1'b0; vl = '0; vsew = '0; vm = 1'b0;
      mask_as_operand = 1'b0; opcode = '0; vs1_idx = '0; vs2_idx = '0; vd_idx = '0;
      repeat (2) @(negedge clk);
      check("rst_start_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_rf_rd_en", rf_rd_en, 0);
      check("rst_lane_vs1", lane_vs1, 0);
      check("rst_wb_data", wb_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // vl=5 unmasked add: groups at 0,2,4, tail lane off in the last one.
      issue(4'd5, 1'b1, 1'b0, VECTOR_ADD, 5'd3);
      check("t1_accept_wait", waits, 0);
      run_instr(0);
      check("t1_done_cycle", done_cyc, 10);
      check("t1_num_wb", n_wb, 3);
      check("t1_num_rd", rd_cnt, 3);
      check("t1_rd_vs1", rd_vs1_last, 11);
      check("t1_base0", wb_base_a[0], 0);
      check("t1_base1", wb_base_a[1], 2);
      check("t1_base2", wb_base_a[2], 4);
      check("t1_en0", wb_len_a[0], 2'b11);
      check("t1_en1", wb_len_a[1], 2'b11);
      check("t1_en2", wb_len_a[2], 2'b01);
      check("t1_vd", wb_vd_a[0], 3);
      check("t1_data0", wb_data_a[0], {64'h0000_0100_0000_0023, 64'h0000_0100_0000_0011});
      check("t1_data2_lane0", wb_data_a[2][63:0], 64'h0000_0100_0000_0059);

      // vl=0 issued back-to-back: accepted the cycle after done, no traffic.
      issue(4'd0, 1'b1, 1'b0, VECTOR_ADD, 5'd1);
      check("t2_accept_wait", waits, 1);
      run_instr(0);
      check("t2_done_cycle", done_cyc, 1);
      check("t2_num_rd", rd_cnt, 0);
      check("t2_num_wb", n_wb, 0);

      // vl=4 masked, v0 = 1,0,0,1.
      v0 = 8'b0000_1001;
      issue(4'd4, 1'b0, 1'b0, VECTOR_ADD, 5'd4);
      run_instr(0);
      check("t3_done_cycle", done_cyc, 7);
      check("t3_num_wb", n_wb, 2);
      check("t3_en0", wb_len_a[0], 2'b01);
      check("t3_en1", wb_len_a[1], 2'b10);
      check("t3_data0_lane0", wb_data_a[0][63:0], 64'h0000_0100_0000_0011);
      check("t3_data1_lane1", wb_data_a[1][127:64], 64'h0000_0100_0000_0047);

      // vl=4 ADC: mask is an operand, v0 = 0,1,0,1.
      v0 = 8'b0000_1010;
      issue(4'd4, 1'b0, 1'b1, VECTOR_ADC, 5'd5);
      run_instr(0);
      check("t4_num_wb", n_wb, 2);
      check("t4_en0", wb_len_a[0], 2'b11);
      check("t4_en1", wb_len_a[1], 2'b11);
      check("t4_mask0", wb_mask_a[0], 2'b10);
      check("t4_mask1", wb_mask_a[1], 2'b10);
      check("t4_lane_opcode", lane_opcode, VECTOR_ADC);
      check("t4_lane_vm", lane_vm, 0);
      check("t4_lane_vsew", lane_vsew, VSEW_64);

      // vl=8 full vector with a stray start_valid while busy.
      v0 = 8'h00;
      issue(4'd8, 1'b1, 1'b0, VECTOR_ADD, 5'd7);
      run_instr(5);
      check("t5_poke_ready", poke_ready, 0);
      check("t5_done_cycle", done_cyc, 13);
      check("t5_num_wb", n_wb, 4);
      check("t5_num_rd", rd_cnt, 4);
      check("t5_last_base", wb_base_a[3], 6);
      check("t5_last_en", wb_len_a[3], 2'b11);
      check("t5_last_vd", wb_vd_a[3], 7);
      check("t5_rd_vs1", rd_vs1_last, 15);
      check("t5_lane_opcode", lane_opcode, VECTOR_ADD);

      // vl=4, reset in the second WB state.
      issue(4'd4, 1'b1, 1'b0, VECTOR_ADD, 5'd2);
      repeat (6) @(negedge clk);
      check("t6_busy_before_rst", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_ready", start_ready, 1);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_wb_en", wb_en, 0);
      check("t6_rst_wb_data", wb_data, 0);
      check("t6_rst_lane_vs1", lane_vs1, 0);
      check("t6_rst_wb_lane_en", wb_lane_en, 0);
      @(negedge clk);
      check("t6_rst_wb_dropped", wb_en, 0);
      rst = 1'b0;
      @(negedge clk);
      issue(4'd2, 1'b1, 1'b0, VECTOR_ADD, 5'd6);
      check("t6_accept_wait", waits, 0);
      run_instr(0);
      check("t6_done_cycle", done_cyc, 4);
      check("t6_num_wb", n_wb, 1);
      check("t6_base", wb_base_a[0], 0);
      check("t6_en", wb_len_a[0], 2'b11);
      check("t6_vd", wb_vd_a[0], 6);
      check("t6_data", wb_data_a[0], {64'h0000_0100_0000_0023, 64'h0000_0100_0000_0011});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
